load_store_unit: RTL and testbench

Sits between the RV32I execute stage and the word-addressed data memory. Accepts one byte-addressed load/store request at a time, checks alignment and range, and issues word accesses to the memory. Performs read-modify-write for byte/halfword stores and sign/zero extension for loads. Returns one response per request.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 37 +++
 rtl/load_store_unit.sv | 120 ++++++++++++
 tb/tb_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the alignment rule used at request decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_RD,
    STORE_WR,
    RESP,
    ERR
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// byte/halfword merge of store data into an existing memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

  // Only the addressed lanes change; the rest of the old word is kept.
  always_comb begin
    store_data = rdata;
    case (funct3)
      F3_B:    store_data[{offset, 3'b000} +: 8]  = wdata[7:0];
      F3_H:    store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one byte-addressed request at a time, issued to a
// word-addressed memory with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic [1:0]        mem_byte_sel,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t  state;
  logic [2:0]  funct3_reg;
  logic [15:0] wdata_half_reg;
  logic [31:0] merge_reg;

  logic        illegal_f3;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign illegal_f3   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
  assign out_of_range = |req_addr[31:ADDR_W+2];
  assign req_err      = illegal_f3 || out_of_range || is_misaligned(req_funct3, req_addr[1:0]);

  assign mem_wdata = merge_reg;

  lsu_align u_align (
    .rdata      (mem_rdata),
    .offset     (mem_byte_sel),
    .funct3     (funct3_reg),
    .wdata      ({16'd0, wdata_half_reg}),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // mem_addr/mem_byte_sel double as the registered request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      funct3_reg     <= 3'd0;
      wdata_half_reg <= 16'd0;
      merge_reg      <= 32'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'd0;
      mem_addr       <= '0;
      mem_byte_sel   <= 2'd0;
      mem_we         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_reg     <= req_funct3;
            wdata_half_reg <= req_wdata[15:0];
            mem_addr       <= req_addr[ADDR_W+1:2];
            mem_byte_sel   <= req_addr[1:0];
            req_ready      <= 1'b0;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= ERR;
            end else if (!req_store) begin
              state <= LOAD;
            end else if (req_funct3 == F3_W) begin
              merge_reg <= req_wdata;
              mem_we    <= 1'b1;
              state     <= STORE_WR;
            end else begin
              state <= STORE_RD;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        STORE_RD: begin
          merge_reg <= store_data;
          mem_we    <= 1'b1;
          state     <= STORE_WR;
        end
        STORE_WR: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP, ERR: begin
          resp_valid   <= 1'b0;
          resp_err     <= 1'b0;
          resp_rdata   <= 32'd0;
          req_ready    <= 1'b1;
          mem_addr     <= '0;
          mem_byte_sel <= 2'd0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random requests against a word-array reference model of the
// memory; responses, latencies and memory writes are checked per request.
module tb_load_store_unit;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [1:0]        mem_byte_sel;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [31:0] pl_data = 32'd0;

  int total = 0;
  int bad = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_byte_sel (mem_byte_sel),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = 12'(w); pl_data = d;
    ref_mem[w] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One request end to end; expectations come from the reference memory.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    logic        exp_err;
    int          exp_lat;
    logic [31:0] old_word, new_word, exp_rdata, sh;
    int          off, widx, we_cnt, we_cyc, got;
    logic [31:0] we_addr, we_data;
    widx = int'(a[13:2]);
    off = int'(a[1:0]);
    exp_err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]) ||
              (a >= 32'h0000_4000) ||
              ((f3 == 3'b001 || f3 == 3'b101) && (off % 2 != 0)) ||
              (f3 == 3'b010 && off != 0);
    old_word = ref_mem[widx];
    new_word = old_word;
    exp_rdata = 32'd0;
    sh = old_word >> (8 * off);
    if (exp_err) exp_lat = 1;
    else if (!st) begin
      exp_lat = 2;
      case (f3)
        3'b000: exp_rdata = 32'($signed(sh[7:0]));
        3'b001: exp_rdata = 32'($signed(sh[15:0]));
        3'b100: exp_rdata = sh & 32'hFF;
        3'b101: exp_rdata = sh & 32'hFFFF;
        default: exp_rdata = old_word;
      endcase
    end else if (f3 == 3'b010) begin
      exp_lat = 2; new_word = wd;
    end else if (f3 == 3'b000) begin
      exp_lat = 3;
      new_word = (old_word & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
    end else begin
      exp_lat = 3;
      new_word = (old_word & ~(32'hFFFF << (8 * off))) | ((wd & 32'hFFFF) << (8 * off));
    end

    @(negedge clk);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    we_cnt = 0; we_cyc = 0; got = 0; we_addr = 0; we_data = 0;
    for (int c = 1; c <= 6 && got == 0; c++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++; we_cyc = c; we_addr = 32'(mem_addr); we_data = mem_wdata;
      end
      if (c < exp_lat) check("ready_low_in_flight", {31'd0, req_ready}, 32'd0);
      if (resp_valid) begin
        got = 1;
        check("resp_latency", 32'(c), 32'(exp_lat));
        check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        check("resp_rdata", resp_rdata, exp_rdata);
      end
    end
    if (got == 0) check("resp_timeout", 32'd0, 32'd1);
    check("we_count", 32'(we_cnt), (st && !exp_err) ? 32'd1 : 32'd0);
    if (st && !exp_err) begin
      check("we_cycle", 32'(we_cyc), 32'(exp_lat - 1));
      check("we_addr", we_addr, 32'(widx));
      check("we_data", we_data, new_word);
      ref_mem[widx] = new_word;
    end
    @(negedge clk);
    if (a < 32'h0000_4000) check("mem_word", mem[widx], ref_mem[widx]);
    $display("req st=%0d f3=%0d addr=%h wdata=%h -> err=%0d rdata=%h", st, f3, a, wd,
             exp_err, exp_rdata);
  endtask

  initial begin
    int acc, rsp, cyc;
    logic [31:0] expq[$];
    logic [31:0] a;
    logic [2:0]  f3;
    logic        st;

    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end

    // Reset state
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_byte_sel", {30'd0, mem_byte_sel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w < 32; w++) preload(w, $urandom);
    preload(3, 32'h8081_F2F3);
    preload(5, 32'h1122_3344);

    // Directed loads with extension
    do_req(1'b0, 3'b000, 32'h0000_000D, 32'd0);
    do_req(1'b0, 3'b100, 32'h0000_000D, 32'd0);
    do_req(1'b0, 3'b101, 32'h0000_000E, 32'd0);
    // SW then LW
    do_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'd0);
    check("sw_word4", mem[4], 32'hDEAD_BEEF);
    // Sub-word read-modify-write
    do_req(1'b1, 3'b000, 32'h0000_0015, 32'h0000_00AA);
    check("sb_word5", mem[5], 32'h1122_AA44);
    do_req(1'b1, 3'b001, 32'h0000_0016, 32'h0000_BBCC);
    check("sh_word5", mem[5], 32'hBBCC_AA44);
    // Errors
    do_req(1'b0, 3'b010, 32'h0000_0002, 32'd0);
    do_req(1'b1, 3'b001, 32'h0000_0001, 32'h1234_5678);
    do_req(1'b0, 3'b011, 32'h0000_0000, 32'd0);
    do_req(1'b0, 3'b010, 32'h0001_0000, 32'd0);
    do_req(1'b1, 3'b100, 32'h0000_0008, 32'h1234_5678);

    // Reset during STORE_RD of an SB
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h0000_0015; req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
    check("rstmid_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_word5", mem[5], ref_mem[5]);
    check("rstmid_ready_after", {31'd0, req_ready}, 32'd1);
    $display("reset during STORE_RD: word5=%h", mem[5]);
    do_req(1'b0, 3'b010, 32'h0000_0014, 32'd0);

    // req_valid held high with alternating LW/SW to word 8
    acc = 0; rsp = 0; cyc = 0;
    @(negedge clk);
    while (rsp < 6 && cyc < 80) begin
      check("held_ready", {31'd0, req_ready}, (acc == rsp) ? 32'd1 : 32'd0);
      if (resp_valid) begin
        check("held_rdata", resp_rdata, expq.pop_front());
        check("held_err", {31'd0, resp_err}, 32'd0);
        rsp++;
        $display("held resp %0d rdata=%h", rsp, resp_rdata);
      end
      if (req_ready && acc < 6) begin
        req_valid = 1'b1;
        req_addr = 32'h0000_0020;
        req_funct3 = 3'b010;
        if (acc % 2 == 0) begin
          req_store = 1'b0; req_wdata = 32'd0;
          expq.push_back(ref_mem[8]);
        end else begin
          req_store = 1'b1; req_wdata = $urandom;
          ref_mem[8] = req_wdata;
          expq.push_back(32'd0);
        end
        acc++;
      end else if (acc >= 6) begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    check("held_responses", 32'(rsp), 32'd6);
    check("held_acceptances", 32'(acc), 32'(rsp));
    @(negedge clk);
    check("held_word8", mem[8], ref_mem[8]);

    // Random requests
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2)) | (st ? 3'b000 : 3'($urandom_range(0, 1) << 2));
      a = {25'd0, 5'($urandom), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(14, 31));
      do_req(st, f3, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
